// File: rtl/mips_alu_unit.sv
// Execute-stage ALU: single-cycle ops finish one cycle after start; multiply and divide iterate ITER cycles.
// Result, flags and the alu_ready pulse are all registered; start is only taken in IDLE.
module mips_alu_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       aluctl,
  output logic [WIDTH-1:0] alu_out_data,
  output logic             alu_ready,
  output logic             busy,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_last;
  logic               neg_q;
  // Shared working registers: multiplicand/multiplier/product for MUL,
  // dividend-then-quotient / divisor magnitude / partial remainder for DIV.
  logic [WIDTH-1:0]   opa, opb, acc;

  logic [4:0]         op_in;
  logic               unused_ifmt;
  logic               go_mul, go_div;
  logic [WIDTH-1:0]   sum, diff;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_ovf, sc_dbz, sc_ill;

  logic [WIDTH-1:0]   mul_acc_nxt;
  logic [WIDTH:0]     div_rem_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem_nxt, div_quo_nxt;

  assign op_in       = aluctl[5:1];
  assign unused_ifmt = aluctl[0];
  assign go_mul      = (op_in == 5'd12);
  assign go_div      = (op_in == 5'd13) && (B != '0);
  assign cnt_last    = (cnt == CNT_W'(ITER - 1));
  assign busy        = (state != IDLE);

  assign sum  = A + B;
  assign diff = A - B;

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_dbz = 1'b0;
    sc_ill = 1'b0;
    case (op_in)
      5'd0:  sc_res = A ^ B;
      5'd9:  sc_res = A | B;
      5'd10: sc_res = ~(A | B);
      5'd14: sc_res = A & B;
      5'd1:  sc_res = B << A[SHW-1:0];
      5'd2:  sc_res = A << B[SHW-1:0];
      5'd3, 5'd5: sc_res = B >> A[SHW-1:0];
      5'd17: sc_res = $unsigned($signed(B) >>> A[SHW-1:0]);
      5'd15: begin
        sc_res = sum;
        sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      5'd11, 5'd23, 5'd24, 5'd25, 5'd26: sc_res = sum;
      5'd4: begin
        sc_res = diff;
        sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      5'd8:  sc_res = B - A;
      5'd6, 5'd27: sc_res = WIDTH'($signed(A) < $signed(B));
      // Only reached single-cycle when B is zero; B!=0 goes to DIV.
      5'd13: begin
        sc_res = '1;
        sc_dbz = 1'b1;
      end
      5'd16: sc_res = A;
      5'd18: sc_res = WIDTH'(A == B);
      5'd19: sc_res = WIDTH'(A != B);
      5'd20: sc_res = WIDTH'($signed(A) <= 0);
      5'd21: sc_res = WIDTH'($signed(A) > 0);
      5'd22: sc_res = WIDTH'($signed(A) >= 0);
      5'd28: sc_res = B << 16;
      5'd29, 5'd30, 5'd31: sc_ill = 1'b1;
      default: sc_res = '0;
    endcase
  end

  // One shift-add step and one restoring-divide step per iteration.
  assign mul_acc_nxt = acc + (opb[0] ? opa : '0);
  assign div_rem_sh  = {acc, opa[WIDTH-1]};
  assign div_ge      = (div_rem_sh >= {1'b0, opb});
  assign div_rem_nxt = div_ge ? (div_rem_sh[WIDTH-1:0] - opb) : div_rem_sh[WIDTH-1:0];
  assign div_quo_nxt = {opa[WIDTH-2:0], div_ge};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = go_mul ? MUL : (go_div ? DIV : DONE);
      MUL:  if (cnt_last) state_nxt = DONE;
      DIV:  if (cnt_last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt          <= '0;
      neg_q        <= 1'b0;
      opa          <= '0;
      opb          <= '0;
      acc          <= '0;
      alu_out_data <= '0;
      alu_ready    <= 1'b0;
      overflow     <= 1'b0;
      div_by_zero  <= 1'b0;
      illegal_op   <= 1'b0;
    end else begin
      alu_ready <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cnt   <= '0;
          acc   <= '0;
          neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
          opa   <= (go_mul || !A[WIDTH-1]) ? A : -A;
          opb   <= (go_mul || !B[WIDTH-1]) ? B : -B;
          if (!go_mul && !go_div) begin
            alu_out_data <= sc_res;
            overflow     <= sc_ovf;
            div_by_zero  <= sc_dbz;
            illegal_op   <= sc_ill;
            alu_ready    <= 1'b1;
          end
        end
        MUL: begin
          cnt <= cnt + CNT_W'(1);
          acc <= mul_acc_nxt;
          opa <= opa << 1;
          opb <= opb >> 1;
          if (cnt_last) begin
            alu_out_data <= mul_acc_nxt;
            overflow     <= 1'b0;
            div_by_zero  <= 1'b0;
            illegal_op   <= 1'b0;
            alu_ready    <= 1'b1;
          end
        end
        DIV: begin
          cnt <= cnt + CNT_W'(1);
          acc <= div_rem_nxt;
          opa <= div_quo_nxt;
          if (cnt_last) begin
            alu_out_data <= neg_q ? -div_quo_nxt : div_quo_nxt;
            overflow     <= 1'b0;
            div_by_zero  <= 1'b0;
            illegal_op   <= 1'b0;
            alu_ready    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_alu_unit.sv
// Scoreboard bench for mips_alu_unit: driver pushes expected responses, monitor pops on alu_ready.
module tb_mips_alu_unit;

  logic        clk = 1'b0;
  logic        rst_b, start;
  logic [31:0] A, B;
  logic [5:0]  aluctl;
  logic [31:0] alu_out_data;
  logic        alu_ready, busy, overflow, div_by_zero, illegal_op;

  mips_alu_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .A(A), .B(B), .aluctl(aluctl),
    .alu_out_data(alu_out_data), .alu_ready(alu_ready), .busy(busy),
    .overflow(overflow), .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] r;
    bit          ov, dz, il;
    longint      at;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: plain signed/unsigned arithmetic on wide integers.
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output bit ov, output bit dz, output bit il,
                       output int lat);
    longint sa, sb, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'h0; ov = 0; dz = 0; il = 0; lat = 1;
    case (op)
      0:  r = a ^ b;
      9:  r = a | b;
      10: r = ~(a | b);
      14: r = a & b;
      1:  r = b << a[4:0];
      2:  r = a << b[4:0];
      3, 5: r = b >> a[4:0];
      17: begin t = sb >>> a[4:0]; r = t[31:0]; end
      15: begin t = sa + sb; r = t[31:0]; ov = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      11, 23, 24, 25, 26: begin t = sa + sb; r = t[31:0]; end
      4:  begin t = sa - sb; r = t[31:0]; ov = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      8:  begin t = sb - sa; r = t[31:0]; end
      6, 27: r = (sa < sb) ? 32'd1 : 32'd0;
      12: begin t = longint'(a) * longint'(b); r = t[31:0]; lat = 33; end
      13: begin
        if (b == 0) begin r = 32'hFFFFFFFF; dz = 1; end
        else begin t = sa / sb; r = t[31:0]; lat = 33; end
      end
      16: r = a;
      7:  r = 0;
      18: r = (a == b) ? 32'd1 : 32'd0;
      19: r = (a != b) ? 32'd1 : 32'd0;
      20: r = (sa <= 0) ? 32'd1 : 32'd0;
      21: r = (sa > 0) ? 32'd1 : 32'd0;
      22: r = (sa >= 0) ? 32'd1 : 32'd0;
      28: r = b << 16;
      default: il = 1;
    endcase
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    A = a;
    B = b;
    aluctl = {op, 1'($urandom_range(0, 1))};
    start = 1'b1;
  endtask

  // Called at the negedge before the sampling edge; ready is seen at the negedge lat cycles on.
  task automatic push(input logic [31:0] r, input bit ov, input bit dz, input bit il, input int lat);
    exp_t e;
    e.r = r; e.ov = ov; e.dz = dz; e.il = il;
    e.at = cyc + lat;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 80 && !done; n++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic issue_exp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input bit ov, input bit dz, input bit il,
                           input int lat);
    drive(op, a, b);
    push(r, ov, dz, il, lat);
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"}, alu_out_data, 0);
    chk({tag, "_ready"}, alu_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_dbz"}, div_by_zero, 0);
    chk({tag, "_ill"}, illegal_op, 0);
  endtask

  // Monitor
  bit   prev_ready = 0;
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_b && alu_ready) begin
        chk("ready_width", {31'b0, prev_ready}, 0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_ready actual=%h expected=no_pulse", alu_out_data);
        end else begin
          mon_e = sb_q.pop_front();
          chk("result", alu_out_data, mon_e.r);
          chk("overflow", overflow, mon_e.ov);
          chk("div_by_zero", div_by_zero, mon_e.dz);
          chk("illegal_op", illegal_op, mon_e.il);
          chk("latency_cycle", 32'(cyc), 32'(mon_e.at));
        end
      end
      prev_ready = alu_ready;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b, r;
    bit          ov, dz, il;
    int          lat;

    rst_b = 1'b0; start = 1'b0; A = '0; B = '0; aluctl = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_b = 1'b1;
    @(negedge clk);

    issue_exp(15, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 0, 0, 1);

    // Reset during MUL iteration ~10 aborts it with no ready pulse.
    drive(12, 32'h3, 32'h5);
    push(32'd15, 0, 0, 0, 33);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk_reset_outputs("midmul_reset");
    void'(sb_q.pop_back());
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_ready", alu_ready, 0);
    issue_exp(15, 32'd5, 32'd7, 32'd12, 0, 0, 0, 1);

    issue_exp(11, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 0, 1);

    // Multiply with busy checked every cycle and an ignored start at cycle 5.
    drive(12, 32'hFFFFFFFD, 32'd7);
    push(32'hFFFFFFEB, 0, 0, 0, 33);
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("mul_busy", busy, 1);
      if (i == 4) drive(0, 32'h1234, 32'h5678);
      else start = 1'b0;
    end
    start = 1'b0;
    wait_idle();

    issue_exp(13, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0, 0, 0, 33);
    issue_exp(13, 32'd100, 32'd0, 32'hFFFFFFFF, 0, 1, 0, 1);
    issue_exp(13, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 0, 33);
    issue_exp(17, 32'd4, 32'hF0000000, 32'hFF000000, 0, 0, 0, 1);
    issue_exp(3, 32'd4, 32'hF0000000, 32'h0F000000, 0, 0, 0, 1);
    issue_exp(28, 32'd0, 32'h00001234, 32'h12340000, 0, 0, 0, 1);
    issue_exp(20, 32'd0, 32'd0, 32'd1, 0, 0, 0, 1);
    issue_exp(21, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1);
    issue_exp(19, 32'd9, 32'd9, 32'd0, 0, 0, 0, 1);
    issue_exp(30, 32'h55, 32'hAA, 32'd0, 0, 0, 1, 1);
    issue_exp(4, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1, 0, 0, 1);

    // Randomized back-to-back traffic against the reference model.
    for (int n = 0; n < 250; n++) begin
      op = 5'($urandom_range(0, 31));
      a = $urandom;
      b = $urandom;
      if (op == 13 && $urandom_range(0, 3) == 0) b = 0;
      if ($urandom_range(0, 4) == 0) a = a & 32'h1F;
      model(op, a, b, r, ov, dz, il, lat);
      issue_exp(op, a, b, r, ov, dz, il, lat);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_alu_unit.md
Name: mips_alu_unit

Overview:
- Execute-stage ALU directly downstream of the control unit: consumes A, B and aluctl, and returns alu_out_data and alu_ready to the control unit.
- Single-cycle logic, shift, compare, address and branch-condition ops complete in 1 cycle.
- Multiply and divide are iterative over 32 cycles, tracked by a small FSM.
- The control unit holds the instruction until alu_ready pulses.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.
- ITER, 32, multiply/divide iteration count. Must equal WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_b  input  1  asynchronous active-low reset.
- start  input  1  operand/op valid. Sampled only in IDLE.
- A  input  32  operand A (rs). Holds the shift count in A[4:0] for shift-by-amount ops.
- B  input  32  operand B (rt or sign-extended immediate).
- aluctl  input  6  op select: aluctl[5:1] = op code, aluctl[0] = I-format flag (ignored here).
- alu_out_data  output  32  result, registered.
- alu_ready  output  1  one-cycle pulse: result valid.
- busy  output  1  high from the accepted start until the alu_ready cycle, inclusive.
- overflow  output  1  signed overflow for ops 15/4. Valid with alu_ready.
- div_by_zero  output  1  op 13 with B==0. Valid with alu_ready.
- illegal_op  output  1  op code 29..31. Valid with alu_ready.

Behaviour:
- Reset (async, rst_b low):
  - FSM goes to IDLE.
  - All outputs go to 0; internal accumulators are cleared.
  - Reset mid multiply/divide aborts it; no alu_ready pulse is issued.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE with start=1 latches A, B and op.
  - op 12 goes to MUL; op 13 with B!=0 goes to DIV; all other ops go to DONE with the result computed from the latched operands.
  - MUL and DIV each run a counter 0..ITER-1 and go to DONE after the last iteration.
  - DONE drives alu_ready=1 for exactly one cycle, then returns to IDLE. A new start is accepted on the cycle after DONE.
  - start while busy is ignored; the latched operands are unaffected.
- Latency, with start sampled at edge k:
  - Single-cycle ops: alu_ready high during cycle k+1.
  - MUL/DIV: alu_ready high during cycle k+1+ITER (33).
- Output hold: alu_out_data holds the last result until the next alu_ready. overflow, div_by_zero and illegal_op are updated only at alu_ready.
- Op codes (aluctl[5:1]):
  - 0 xor; 9 or; 10 nor; 14 and.
  - 1: B << A[4:0]. 2: A << B[4:0].
  - 3: B >> A[4:0], logical. 5: B >> A[4:0], logical.
  - 17: B >>> A[4:0], arithmetic.
  - 15: A+B, sets overflow on signed overflow. 11: A+B, overflow=0.
  - 4: A-B, sets overflow on signed overflow. 8: B-A, overflow=0.
  - 6 and 27: signed A<B gives 1, else 0.
  - 12: low 32 bits of A*B, via shift-add. Signed and unsigned results are identical in the low word.
  - 13: signed A/B, truncating toward zero.
    - Restoring divide on magnitudes; quotient negated when sign(A)!=sign(B).
    - B==0: skips DIV; result 32'hFFFFFFFF, div_by_zero=1, single-cycle latency.
  - 16: A (jr target). 7: 0 (halt; the control unit asserts halted).
  - Branch conditions (result is 1 if the condition holds, else 0): 18 A==B; 19 A!=B; 20 signed A<=0; 21 signed A>0; 22 signed A>=0.
  - 23..26: A+B effective address, overflow=0.
  - 28: B << 16.
  - 29..31: result 0, illegal_op=1.
- Width: all arithmetic is modulo 2^32; divide-by-zero and overflow never trap.
- 32'h80000000 / -1: result 32'h80000000, div_by_zero=0.

Test Plan:
- Reset: assert rst_b=0 during MUL iteration 10 -> outputs 0, no alu_ready; next op 15, A=5, B=7 -> 12 at k+1.
- Add overflow: op 15, A=32'h7FFFFFFF, B=1 -> 32'h80000000, overflow=1. Op 11, same operands -> overflow=0.
- Multiply: op 12, A=32'hFFFFFFFD (-3), B=7 -> 32'hFFFFFFEB.
  - alu_ready exactly 33 cycles after start; busy high throughout.
  - A second start at cycle 5 is ignored.
- Divide: op 13, A=-7, B=2 -> 32'hFFFFFFFD at cycle 33.
  - A=100, B=0 -> 32'hFFFFFFFF, div_by_zero=1 at cycle 1.
  - A=32'h80000000, B=-1 -> 32'h80000000.
- Shifts and lui:
  - Op 17, B=32'hF0000000, A=4 -> 32'hFF000000.
  - Op 3, same operands -> 32'h0F000000.
  - Op 28, B=32'h00001234 -> 32'h12340000.
- Branches and illegal:
  - Op 20, A=0 -> 1. Op 21, A=0 -> 0. Op 19, A=B=9 -> 0.
  - Op 30 -> result 0, illegal_op=1.
  - Back-to-back single-cycle ops issued every 2 cycles -> every alu_ready pulse is exactly 1 cycle wide.
